// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants and state encoding for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int NUM_CODES = 16;
  localparam int CODE_W    = 4;
  localparam int ERR_W     = 5;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Per-code settle counter: counts up while enabled, flags the sample cycle.
module settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 16 input codes of a 4-in/2-out block, checks outputs against
// EXP_X/EXP_Y and reports error count, first failing code and pass.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                     SETTLE = 2,
  parameter logic [NUM_CODES-1:0]   EXP_X  = 16'h0000,
  parameter logic [NUM_CODES-1:0]   EXP_Y  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dut_x,
  input  logic              dut_y,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [CODE_W-1:0] first_fail
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   idx_q, idx_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [CODE_W-1:0]   ff_q, ff_d;
  logic                fv_q, fv_d;
  logic                pass_q, pass_d;

  logic                tc, accept, sample, mism, last;
  logic [CNT_W-1:0]    cnt_unused;

  assign accept = (state_q == ST_IDLE) && start;
  assign sample = (state_q == ST_SETTLE) && tc;
  assign last   = (idx_q == CODE_W'(NUM_CODES - 1));
  assign mism   = (dut_x != EXP_X[idx_q]) || (dut_y != EXP_Y[idx_q]);

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept || sample),
    .en_i  (state_q == ST_SETTLE),
    .cnt_o (cnt_unused),
    .tc_o  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (sample && last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Result registers; pass is resolved on the final sample so it is valid with done.
  always_comb begin
    idx_d  = idx_q;
    err_d  = err_q;
    ff_d   = ff_q;
    fv_d   = fv_q;
    pass_d = pass_q;
    if (accept) begin
      idx_d  = '0;
      err_d  = '0;
      ff_d   = '0;
      fv_d   = 1'b0;
      pass_d = 1'b0;
    end else if (sample) begin
      if (mism) begin
        err_d = err_q + ERR_W'(1);
        if (!fv_q) begin
          ff_d = idx_q;
          fv_d = 1'b1;
        end
      end
      if (last) pass_d = (err_d == '0);
      else      idx_d  = idx_q + CODE_W'(1);
    end
  end

  always_comb begin
    busy         = (state_q == ST_SETTLE);
    done         = (state_q == ST_DONE);
    {a, b, c, d} = busy ? idx_q : '0;
    pass         = pass_q;
    err_count    = err_q;
    fail_valid   = fv_q;
    first_fail   = ff_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweepers (SETTLE=2 and SETTLE=1) checking a reference block.
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP_X = 16'hF888;  // a&b | c&d
  localparam logic [15:0] EXP_Y = 16'h6996;  // a^b^c^d

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, start2, x2, y2, a2, b2, c2, d2, busy2, done2, pass2, fv2;
  logic [4:0] err2;
  logic [3:0] ff2, code2;
  logic rst1, start1, x1, y1, a1, b1, c1, d1, busy1, done1, pass1, fv1;
  logic [4:0] err1;
  logic [3:0] ff1;

  int fault_mode = 0;
  int n_cmp = 0;
  int n_bad = 0;

  assign code2 = {a2, b2, c2, d2};

  // Reference block with fault injection for the SETTLE=2 instance.
  always_comb begin
    logic xm, ym;
    xm = (a2 & b2) | (c2 & d2);
    ym = a2 ^ b2 ^ c2 ^ d2;
    x2 = xm;
    y2 = ym;
    case (fault_mode)
      1: y2 = (code2 == 4'd5) ? ~ym : ym;
      2: x2 = 1'b0;
      3: x2 = ~xm;
      4: y2 = (code2 == 4'd15) ? ~ym : ym;
      default: ;
    endcase
  end

  assign x1 = (a1 & b1) | (c1 & d1);
  assign y1 = a1 ^ b1 ^ c1 ^ d1;

  truth_table_sweeper #(.SETTLE(2), .EXP_X(EXP_X), .EXP_Y(EXP_Y)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .dut_x(x2), .dut_y(y2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .first_fail(ff2)
  );

  truth_table_sweeper #(.SETTLE(1), .EXP_X(EXP_X), .EXP_Y(EXP_Y)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .dut_x(x1), .dut_y(y1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail(ff1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Pulse start on dut2 and follow the sweep; lat counts the start cycle as 1.
  task automatic sweep2(input int fault, output int lat, output bit seq_ok);
    seq_ok = 1'b1;
    lat = -1;
    fault_mode = fault;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done2) begin
        lat = k + 1;
        break;
      end
      if (!busy2 || code2 != 4'(k / 2)) seq_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_code2(input logic [3:0] code, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (busy2 && code2 == code) hit = 1'b1;
    end
  endtask

  typedef struct {
    int fault;
    int err;
    int ff;
    int fv;
    int ps;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int lat;
    bit seq_ok, hit, mono;
    int ndone, prev, maxc, cyc, nd;
    int dt[3];

    tbl[0] = '{fault: 0, err: 0,  ff: 0,  fv: 0, ps: 1};
    tbl[1] = '{fault: 1, err: 1,  ff: 5,  fv: 1, ps: 0};
    tbl[2] = '{fault: 2, err: 7,  ff: 3,  fv: 1, ps: 0};
    tbl[3] = '{fault: 3, err: 16, ff: 0,  fv: 1, ps: 0};
    tbl[4] = '{fault: 4, err: 1,  ff: 15, fv: 1, ps: 0};

    rst2 = 1'b1; rst1 = 1'b1; start2 = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_pass", pass2, 0);
    chk("rst_err", err2, 0);
    chk("rst_fv", fv2, 0);
    chk("rst_ff", ff2, 0);
    chk("rst_code", code2, 0);
    @(negedge clk); rst2 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy2, 0);

    foreach (tbl[i]) begin
      sweep2(tbl[i].fault, lat, seq_ok);
      chk($sformatf("v%0d_latency", i), lat, 33);
      chk($sformatf("v%0d_codeseq", i), seq_ok, 1);
      chk($sformatf("v%0d_err", i), err2, tbl[i].err);
      chk($sformatf("v%0d_ff", i), ff2, tbl[i].ff);
      chk($sformatf("v%0d_fv", i), fv2, tbl[i].fv);
      chk($sformatf("v%0d_pass", i), pass2, tbl[i].ps);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_1cyc", i), done2, 0);
      chk($sformatf("v%0d_pass_held", i), pass2, tbl[i].ps);
      chk($sformatf("v%0d_idle_code", i), code2, 0);
    end

    // Reset while code 9 is driven, mid-sweep with one error already counted.
    fault_mode = 1;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    wait_code2(4'd9, hit);
    chk("rst_reach_code9", hit, 1);
    chk("pre_rst_err", err2, 1);
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy2, 0);
    chk("midrst_code", code2, 0);
    chk("midrst_err", err2, 0);
    chk("midrst_done", done2, 0);
    @(negedge clk); rst2 = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done2) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    sweep2(0, lat, seq_ok);
    chk("post_rst_latency", lat, 33);
    chk("post_rst_seq", seq_ok, 1);
    chk("post_rst_err", err2, 0);
    chk("post_rst_pass", pass2, 1);

    // start pulsed during code 7 must not restart the sweep.
    fault_mode = 0;
    repeat (2) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    wait_code2(4'd7, hit);
    chk("mid_reach_code7", hit, 1);
    start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    mono = 1'b1; prev = 7; maxc = 7; ndone = 0;
    repeat (60) begin
      if (busy2) begin
        if (int'(code2) != prev && int'(code2) != prev + 1) mono = 1'b0;
        prev = int'(code2);
        if (prev > maxc) maxc = prev;
      end
      if (done2) ndone++;
      @(negedge clk);
    end
    chk("midstart_monotonic", mono, 1);
    chk("midstart_last_code", maxc, 15);
    chk("midstart_one_done", ndone, 1);
    chk("midstart_pass", pass2, 1);

    // SETTLE=1 with start held: first done at 17, then every 18 cycles.
    @(negedge clk); start1 = 1'b1;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done1) begin
        dt[nd] = cyc;
        chk($sformatf("s1_pass%0d", nd), pass1, 1);
        nd++;
      end
    end
    start1 = 1'b0;
    chk("s1_done_count", nd, 3);
    if (nd == 3) begin
      chk("s1_first_latency", dt[0], 17);
      chk("s1_period_a", dt[1] - dt[0], 18);
      chk("s1_period_b", dt[2] - dt[1], 18);
    end
    chk("s1_err", err1, 0);
    chk("s1_fv", fv1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
